// File: rtl/mult_div_hilo_pkg.sv
// Shared types and defaults for the multi-cycle MULT/DIV unit that owns HI and LO.
package mult_div_hilo_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefIters = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMult = 2'd1,
    StDiv  = 2'd2,
    StDone = 2'd3
  } state_e;

endpackage

// File: rtl/mult_div_hilo_if.sv
// Control/operand/result bundle between the MIPS control path and the MULT/DIV unit.
interface mult_div_hilo_if
  import mult_div_hilo_pkg::*;
#(
  parameter int unsigned Width = DefWidth
) ();

  logic             start_mult;
  logic             start_div;
  logic             mthi;
  logic             mtlo;
  logic [Width-1:0] A_in;
  logic [Width-1:0] B_in;
  logic [Width-1:0] HI_Out;
  logic [Width-1:0] LO_Out;
  logic             busy;
  logic             done;
  logic             div_zero;

  modport master (
    output start_mult, start_div, mthi, mtlo, A_in, B_in,
    input  HI_Out, LO_Out, busy, done, div_zero
  );

  modport slave (
    input  start_mult, start_div, mthi, mtlo, A_in, B_in,
    output HI_Out, LO_Out, busy, done, div_zero
  );

endinterface

// File: rtl/mult_div_hilo_div_step.sv
// One restoring-division step on unsigned magnitudes: shift in the next dividend bit, try subtract.
module mult_div_hilo_div_step #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] rem_i,
  input  logic [Width-1:0] quot_i,
  input  logic [Width-1:0] dvsr_i,
  output logic [Width-1:0] rem_o,
  output logic [Width-1:0] quot_o
);

  logic [Width:0] shifted;
  logic [Width:0] diff;
  logic           fits;

  always_comb begin
    shifted = {rem_i, quot_i[Width-1]};
    diff    = shifted - {1'b0, dvsr_i};
    fits    = (shifted >= {1'b0, dvsr_i});
    // Remainder stays below the divisor, so the top bit is always zero here.
    rem_o   = fits ? diff[Width-1:0] : shifted[Width-1:0];
    quot_o  = {quot_i[Width-2:0], fits};
  end

endmodule

// File: rtl/mult_div_hilo.sv
// Signed multi-cycle MULT (Booth radix-2) / DIV (restoring) unit holding the HI and LO registers.
module mult_div_hilo
  import mult_div_hilo_pkg::*;
#(
  parameter int unsigned Width = DefWidth,
  parameter int unsigned Iters = DefIters
) (
  input logic            clk,
  input logic            reset,
  mult_div_hilo_if.slave bus
);

  localparam int unsigned CntW = $clog2(Iters + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(Iters);

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*Width:0]   booth_q, booth_d;
  logic [Width-1:0]   mcand_q, mcand_d;
  logic [Width-1:0]   rem_q, rem_d, quot_q, quot_d, dvsr_q, dvsr_d;
  logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d, dz_q, dz_d;
  logic [Width-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic [Width:0]     acc_ext, mcand_ext, sum_ext;
  logic [Width-1:0]   rem_step, quot_step;

  mult_div_hilo_div_step #(.Width(Width)) u_div_step (
    .rem_i  (rem_q),
    .quot_i (quot_q),
    .dvsr_i (dvsr_q),
    .rem_o  (rem_step),
    .quot_o (quot_step)
  );

  // Accumulator is widened by one bit so the shift keeps the true sign even for -2^(W-1).
  always_comb begin
    acc_ext   = {booth_q[2*Width], booth_q[2*Width:Width+1]};
    mcand_ext = {mcand_q[Width-1], mcand_q};
    case (booth_q[1:0])
      2'b01:   sum_ext = acc_ext + mcand_ext;
      2'b10:   sum_ext = acc_ext - mcand_ext;
      default: sum_ext = acc_ext;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    booth_d  = booth_q;
    mcand_d  = mcand_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvsr_d   = dvsr_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start_mult) begin
          state_d = StMult;
          cnt_d   = '0;
          booth_d = {{Width{1'b0}}, bus.A_in, 1'b0};
          mcand_d = bus.B_in;
          dz_d    = 1'b0;
        end else if (bus.start_div) begin
          state_d  = StDiv;
          cnt_d    = '0;
          sign_a_d = bus.A_in[Width-1];
          sign_b_d = bus.B_in[Width-1];
          rem_d    = '0;
          quot_d   = bus.A_in[Width-1] ? -bus.A_in : bus.A_in;
          dvsr_d   = bus.B_in[Width-1] ? -bus.B_in : bus.B_in;
          dz_d     = (bus.B_in == '0);
        end else begin
          if (bus.mthi) hi_d = bus.A_in;
          if (bus.mtlo) lo_d = bus.A_in;
        end
      end
      StMult: begin
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          hi_d    = booth_q[2*Width:Width+1];
          lo_d    = booth_q[Width:1];
        end else begin
          booth_d = {sum_ext, booth_q[Width:1]};
          cnt_d   = cnt_q + CntW'(1);
        end
      end
      StDiv: begin
        if (dz_q) begin
          state_d = StDone;
        end else if (cnt_q == LastCnt) begin
          state_d = StDone;
          lo_d    = (sign_a_q ^ sign_b_q) ? -quot_q : quot_q;
          hi_d    = sign_a_q ? -rem_q : rem_q;
        end else begin
          rem_d  = rem_step;
          quot_d = quot_step;
          cnt_d  = cnt_q + CntW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      booth_q  <= '0;
      mcand_q  <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvsr_q   <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      booth_q  <= booth_d;
      mcand_q  <= mcand_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvsr_q   <= dvsr_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  always_comb begin
    bus.HI_Out   = hi_q;
    bus.LO_Out   = lo_q;
    bus.busy     = (state_q != StIdle);
    bus.done     = (state_q == StDone);
    bus.div_zero = (state_q == StDone) && dz_q;
  end

endmodule
